// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle 16-bit-class CPU (FETCH/EXEC/MEM sequencing).
// Instruction and data memories are external, reached through req/ack
// handshakes that accept any number of wait states.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   START             one-cycle pulse, leaves IDLE and begins fetching at PC
//   IM_Req/IM_Addr    instruction fetch request and address (= PC)
//   IM_Ack/IM_RData   fetch completion and 26-bit instruction word
//   DM_Req/DM_We      data access request, 1 = store / 0 = load
//   DM_Addr/DM_WData  data address (ALU result) and store data (rt)
//   DM_Ack/DM_RData   data access completion and load data
//   PC_Out            current PC
//   Retire            one-cycle pulse per completed instruction
//   Halted            HALT has executed
//   Err               sticky illegal-opcode/funct flag
module cpu_multicycle #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              IM_Req,
  output logic [PC_W-1:0]   IM_Addr,
  input  logic              IM_Ack,
  input  logic [25:0]       IM_RData,
  output logic              DM_Req,
  output logic              DM_We,
  output logic [PC_W-1:0]   DM_Addr,
  output logic [DATA_W-1:0] DM_WData,
  input  logic              DM_Ack,
  input  logic [DATA_W-1:0] DM_RData,
  output logic [PC_W-1:0]   PC_Out,
  output logic              Retire,
  output logic              Halted,
  output logic              Err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [PC_W-1:0]   PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] D_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] D_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [25:0]       r_ir;
  logic [DATA_W-1:0] r_regs [0:7];
  logic              r_im_req;
  logic              r_dm_req;
  logic              r_dm_we;
  logic [PC_W-1:0]   r_dm_addr;
  logic [DATA_W-1:0] r_dm_wdata;
  logic              r_halted;
  logic              r_err;

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [2:0]        w_rs;
  logic [2:0]        w_rt;
  logic [2:0]        w_rd;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_jt;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_br_target;
  logic [PC_W-1:0]   w_next_pc;
  logic [2:0]        w_wr_idx;
  logic              w_wr_en;
  logic              w_illegal;
  logic              w_is_mem;
  logic              w_is_halt;

  assign w_op     = r_ir[25:20];
  assign w_rs     = r_ir[19:17];
  assign w_rt     = r_ir[16:14];
  assign w_rd     = r_ir[13:11];
  assign w_funct  = r_ir[5:0];
  assign w_imm    = {{(DATA_W-14){r_ir[13]}}, r_ir[13:0]};
  // R0 is hard-wired to zero on the read side; writes to it are dropped below.
  assign w_rs_val = (w_rs == 3'd0) ? D_ZERO : r_regs[w_rs];
  assign w_rt_val = (w_rt == 3'd0) ? D_ZERO : r_regs[w_rt];
  assign w_pc_inc    = r_pc + PC_ONE;
  assign w_br_target = w_pc_inc + w_imm[PC_W-1:0];

  // Decode the latched IR: ALU result, register write target and next PC.
  always_comb begin
    w_alu     = D_ZERO;
    w_wr_en   = 1'b0;
    w_wr_idx  = 3'd0;
    w_next_pc = w_pc_inc;
    w_illegal = 1'b0;
    w_is_mem  = 1'b0;
    w_is_halt = 1'b0;
    w_jt      = D_ZERO;
    w_jt[15:0] = r_ir[15:0];
    case (w_op)
      OP_RTYPE: begin
        w_wr_en  = 1'b1;
        w_wr_idx = w_rd;
        case (w_funct)
          FN_ADD:  w_alu = w_rs_val + w_rt_val;
          FN_SUB:  w_alu = w_rs_val - w_rt_val;
          FN_AND:  w_alu = w_rs_val & w_rt_val;
          FN_OR:   w_alu = w_rs_val | w_rt_val;
          FN_NOR:  w_alu = ~(w_rs_val | w_rt_val);
          FN_SLT:  w_alu = ($signed(w_rs_val) < $signed(w_rt_val)) ? D_ONE : D_ZERO;
          default: begin
            w_illegal = 1'b1;
            w_wr_en   = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        w_alu    = w_rs_val + w_imm;
        w_wr_en  = 1'b1;
        w_wr_idx = w_rt;
      end
      OP_LW, OP_SW: begin
        w_alu    = w_rs_val + w_imm;
        w_is_mem = 1'b1;
      end
      OP_BEQ: begin
        if (w_rs_val == w_rt_val) w_next_pc = w_br_target;
        else                      w_next_pc = w_pc_inc;
      end
      OP_BNE: begin
        if (w_rs_val != w_rt_val) w_next_pc = w_br_target;
        else                      w_next_pc = w_pc_inc;
      end
      OP_J:    w_next_pc = w_jt[PC_W-1:0];
      OP_HALT: w_is_halt = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end

  // Sequencer: state, PC, IR, register file and the registered bus outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= 26'd0;
      r_im_req   <= 1'b0;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= {PC_W{1'b0}};
      r_dm_wdata <= D_ZERO;
      r_halted   <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= D_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state  <= S_FETCH;
            r_im_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (IM_Ack) begin
            r_ir     <= IM_RData;
            r_im_req <= 1'b0;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_halt) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_is_mem) begin
            // Address/data are frozen here and held until the ack cycle.
            r_state    <= S_MEM;
            r_dm_req   <= 1'b1;
            r_dm_we    <= (w_op == OP_SW);
            r_dm_addr  <= w_alu[PC_W-1:0];
            r_dm_wdata <= w_rt_val;
          end else begin
            if (w_wr_en && (w_wr_idx != 3'd0)) r_regs[w_wr_idx] <= w_alu;
            r_pc     <= w_next_pc;
            r_err    <= r_err | w_illegal;
            r_im_req <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_MEM: begin
          if (DM_Ack) begin
            if (!r_dm_we && (w_rt != 3'd0)) r_regs[w_rt] <= DM_RData;
            r_dm_req <= 1'b0;
            r_dm_we  <= 1'b0;
            r_pc     <= w_pc_inc;
            r_im_req <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: begin
          r_state  <= S_IDLE;
          r_im_req <= 1'b0;
          r_dm_req <= 1'b0;
        end
      endcase
    end
  end

  // Retire marks the cycle whose edge commits; in MEM that is the ack cycle,
  // which cannot be known a cycle ahead, so it is decoded from state + ack.
  assign Retire   = ((r_state == S_EXEC) && !w_is_mem) ||
                    ((r_state == S_MEM) && DM_Ack);
  assign IM_Req   = r_im_req;
  assign IM_Addr  = r_pc;
  assign DM_Req   = r_dm_req;
  assign DM_We    = r_dm_we;
  assign DM_Addr  = r_dm_addr;
  assign DM_WData = r_dm_wdata;
  assign PC_Out   = r_pc;
  assign Halted   = r_halted;
  assign Err      = r_err;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle: table of ALU programs with a store
// scoreboard, plus hand-written sequences for loads with wait states,
// branches/jumps, reset during a data access, illegal opcodes and HALT.
module tb_cpu_multicycle;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        IM_Req;
  logic [15:0] IM_Addr;
  logic        IM_Ack = 1'b0;
  logic [25:0] IM_RData = 26'd0;
  logic        DM_Req;
  logic        DM_We;
  logic [15:0] DM_Addr;
  logic [15:0] DM_WData;
  logic        DM_Ack = 1'b0;
  logic [15:0] DM_RData = 16'd0;
  logic [15:0] PC_Out;
  logic        Retire;
  logic        Halted;
  logic        Err;

  cpu_multicycle #(.DATA_W(16), .PC_W(16), .RESET_PC(16'h0000)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .IM_Req(IM_Req), .IM_Addr(IM_Addr), .IM_Ack(IM_Ack), .IM_RData(IM_RData),
    .DM_Req(DM_Req), .DM_We(DM_We), .DM_Addr(DM_Addr), .DM_WData(DM_WData),
    .DM_Ack(DM_Ack), .DM_RData(DM_RData),
    .PC_Out(PC_Out), .Retire(Retire), .Halted(Halted), .Err(Err)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [15:0] addr; logic [15:0] data; } st_t;
  typedef struct {
    logic [5:0]  funct;
    logic [13:0] a;
    logic [13:0] b;
    logic [15:0] exp;
    int          iw;
    int          dw;
  } vec_t;

  logic [25:0] imem [0:255];
  logic [15:0] dmem [0:255];
  st_t         exp_q[$];
  logic [15:0] pcq[$];
  int          im_wait = 0, dm_wait = 0, im_cnt = 0, dm_cnt = 0;
  bit          resp_en = 1'b1;
  int          checks = 0, errors = 0;

  localparam logic [25:0] HALT_W = {6'h3F, 20'd0};

  function automatic logic [25:0] enc_i(input logic [5:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [13:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [25:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [2:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [25:0] enc_j(input logic [15:0] jt);
    return {6'h02, 4'd0, jt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic store_seen(input logic [15:0] a, input logic [15:0] d);
    st_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_store actual=%0h:%0h expected=none", a, d);
    end else begin
      e = exp_q.pop_front();
      chk("store_addr", {16'd0, a}, {16'd0, e.addr});
      chk("store_data", {16'd0, d}, {16'd0, e.data});
    end
  endtask

  // Memory responder: decides acks on the falling edge with programmable waits.
  initial begin
    forever begin
      @(negedge CLK);
      if (resp_en) begin
        if (IM_Req) begin
          if (im_cnt >= im_wait) begin
            IM_Ack = 1'b1;
            IM_RData = imem[IM_Addr[7:0]];
          end else begin
            IM_Ack = 1'b0;
            im_cnt++;
          end
        end else begin
          IM_Ack = 1'b0;
          im_cnt = 0;
        end
        if (DM_Req) begin
          if (dm_cnt >= dm_wait) begin
            DM_Ack = 1'b1;
            if (DM_We) begin
              if (!RST) begin
                dmem[DM_Addr[7:0]] = DM_WData;
                store_seen(DM_Addr, DM_WData);
              end
            end else begin
              DM_RData = dmem[DM_Addr[7:0]];
            end
          end else begin
            DM_Ack = 1'b0;
            dm_cnt++;
          end
        end else begin
          DM_Ack = 1'b0;
          dm_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    START = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic load_clear();
    for (int i = 0; i < 256; i++) begin
      imem[i] = HALT_W;
      dmem[i] = 16'd0;
    end
    pcq.delete();
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // Start the program and run to HALT, tracking retires and the PC trace.
  task automatic run_prog(input int budget, input int nth, output int n_ret, output int nth_cyc);
    int cyc;
    bit pend;
    n_ret = 0;
    nth_cyc = -1;
    pend = 1'b0;
    step();
    pulse_start();
    cyc = 1;
    while (cyc <= budget && !Halted) begin
      if (pend) begin
        pend = 1'b0;
        if (pcq.size() > 0) chk("pc_trace", {16'd0, PC_Out}, {16'd0, pcq.pop_front()});
      end
      if (Retire) begin
        n_ret++;
        if (n_ret == nth) nth_cyc = cyc;
        pend = 1'b1;
      end
      step();
      cyc++;
    end
    chk("halt_reached", {31'd0, Halted}, 32'd1);
  endtask

  vec_t vecs [12];
  int   nr, nc, cnt;
  bit   addr_ok;
  logic [25:0] bad_w [2];

  initial begin
    vecs[0]  = '{6'h20, 14'd5,     14'd7,     16'h000C, 0, 0};
    vecs[1]  = '{6'h22, 14'd3,     14'd5,     16'hFFFE, 0, 0};
    vecs[2]  = '{6'h24, 14'h1234,  14'h0FF0,  16'h0230, 1, 0};
    vecs[3]  = '{6'h25, 14'h1200,  14'h0034,  16'h1234, 0, 2};
    vecs[4]  = '{6'h27, 14'h00FF,  14'h0F00,  16'hF000, 0, 0};
    vecs[5]  = '{6'h2A, 14'd3,     14'd5,     16'h0001, 0, 0};
    vecs[6]  = '{6'h2A, 14'd5,     14'd3,     16'h0000, 0, 0};
    vecs[7]  = '{6'h2A, 14'h3FFF,  14'd1,     16'h0001, 2, 1};
    vecs[8]  = '{6'h20, 14'h3FFF,  14'd1,     16'h0000, 0, 0};
    vecs[9]  = '{6'h22, 14'd0,     14'd1,     16'hFFFF, 0, 0};
    vecs[10] = '{6'h20, 14'h1FFF,  14'h1FFF,  16'h3FFE, 0, 0};
    vecs[11] = '{6'h2A, 14'd1,     14'h2000,  16'h0000, 1, 3};

    load_clear();
    do_reset();
    chk("rst_im_req", {31'd0, IM_Req}, 32'd0);
    chk("rst_dm_req", {31'd0, DM_Req}, 32'd0);
    chk("rst_dm_we",  {31'd0, DM_We},  32'd0);
    chk("rst_retire", {31'd0, Retire}, 32'd0);
    chk("rst_halted", {31'd0, Halted}, 32'd0);
    chk("rst_err",    {31'd0, Err},    32'd0);
    chk("rst_pc",     {16'd0, PC_Out}, 32'd0);

    // ALU table: ADDI R1; ADDI R2; op R3,R1,R2; SW R3,i(R0); HALT
    for (int i = 0; i < 12; i++) begin
      do_reset();
      load_clear();
      im_wait = vecs[i].iw;
      dm_wait = vecs[i].dw;
      imem[0] = enc_i(6'h08, 3'd0, 3'd1, vecs[i].a);
      imem[1] = enc_i(6'h08, 3'd0, 3'd2, vecs[i].b);
      imem[2] = enc_r(3'd1, 3'd2, 3'd3, vecs[i].funct);
      imem[3] = enc_i(6'h2B, 3'd0, 3'd3, i[13:0]);
      exp_q.push_back('{i[15:0], vecs[i].exp});
      run_prog(300, 4, nr, nc);
      chk("alu_4th_retire_cycle", nc, 9 + 4 * vecs[i].iw + vecs[i].dw);
      chk("alu_retires", nr, 5);
      chk("alu_store_done", exp_q.size(), 0);
      chk("alu_err", {31'd0, Err}, 32'd0);
    end
    im_wait = 0;
    dm_wait = 0;

    // LW with three wait states, then store the loaded value back.
    do_reset();
    load_clear();
    dmem[8'h20] = 16'hBEEF;
    imem[0] = enc_i(6'h23, 3'd0, 3'd1, 14'h0020);
    imem[1] = enc_i(6'h2B, 3'd0, 3'd1, 14'h0021);
    exp_q.push_back('{16'h0021, 16'hBEEF});
    dm_wait = 3;
    step();
    pulse_start();
    for (int k = 0; k < 30 && !DM_Req; k++) step();
    cnt = 0;
    addr_ok = 1'b1;
    while (DM_Req && cnt < 20) begin
      if (DM_Addr !== 16'h0020 || DM_We !== 1'b0) addr_ok = 1'b0;
      cnt++;
      step();
    end
    chk("lw_req_cycles", cnt, 4);
    chk("lw_addr_stable", {31'd0, addr_ok}, 32'd1);
    for (int k = 0; k < 100 && !Halted; k++) step();
    chk("lw_halted", {31'd0, Halted}, 32'd1);
    chk("lw_store_done", exp_q.size(), 0);
    dm_wait = 0;

    // Branches, jumps and the zero register.
    do_reset();
    load_clear();
    imem[0]  = enc_i(6'h08, 3'd0, 3'd0, 14'd9);
    imem[1]  = enc_i(6'h2B, 3'd0, 3'd0, 14'd3);
    imem[2]  = enc_j(16'h0005);
    imem[4]  = enc_j(16'h0010);
    imem[5]  = enc_i(6'h04, 3'd0, 3'd0, 14'h3FFE);
    imem[16] = enc_i(6'h05, 3'd0, 3'd0, 14'd5);
    imem[17] = enc_i(6'h08, 3'd0, 3'd1, 14'd1);
    imem[18] = enc_i(6'h05, 3'd1, 3'd0, 14'd3);
    exp_q.push_back('{16'h0003, 16'h0000});
    pcq.push_back(16'h0001); pcq.push_back(16'h0002); pcq.push_back(16'h0005);
    pcq.push_back(16'h0004); pcq.push_back(16'h0010); pcq.push_back(16'h0011);
    pcq.push_back(16'h0012); pcq.push_back(16'h0016);
    run_prog(300, 0, nr, nc);
    chk("br_retires", nr, 9);
    chk("br_pc_trace_consumed", pcq.size(), 0);
    chk("br_store_done", exp_q.size(), 0);

    // Reset while a store waits for its ack; a late ack must be ignored.
    do_reset();
    load_clear();
    imem[0] = enc_i(6'h2B, 3'd0, 3'd0, 14'd7);
    dm_wait = 20;
    step();
    pulse_start();
    for (int k = 0; k < 30 && !DM_Req; k++) step();
    chk("rstmem_req_seen", {31'd0, DM_Req}, 32'd1);
    step();
    RST = 1'b1;
    step();
    chk("rstmem_dm_req", {31'd0, DM_Req}, 32'd0);
    chk("rstmem_pc", {16'd0, PC_Out}, 32'd0);
    RST = 1'b0;
    resp_en = 1'b0;
    IM_Ack = 1'b0;
    DM_Ack = 1'b1;
    step();
    step();
    chk("late_ack_dm_req", {31'd0, DM_Req}, 32'd0);
    chk("late_ack_retire", {31'd0, Retire}, 32'd0);
    chk("late_ack_pc", {16'd0, PC_Out}, 32'd0);
    chk("late_ack_im_req", {31'd0, IM_Req}, 32'd0);
    DM_Ack = 1'b0;
    pulse_start();
    chk("idle_start_fetch", {31'd0, IM_Req}, 32'd1);
    chk("idle_start_addr", {16'd0, IM_Addr}, 32'd0);
    do_reset();
    resp_en = 1'b1;
    dm_wait = 0;
    chk("rstmem_no_store", exp_q.size(), 0);

    // Illegal opcode and illegal funct execute as NOP, then HALT.
    bad_w[0] = {6'h11, 20'd0};
    bad_w[1] = enc_r(3'd1, 3'd2, 3'd3, 6'h21);
    for (int i = 0; i < 2; i++) begin
      do_reset();
      load_clear();
      imem[0] = bad_w[i];
      run_prog(100, 1, nr, nc);
      chk("ill_retires", nr, 2);
      chk("ill_first_retire_cycle", nc, 2);
      chk("ill_err", {31'd0, Err}, 32'd1);
      chk("ill_pc", {16'd0, PC_Out}, 32'd1);
      chk("halt_im_req", {31'd0, IM_Req}, 32'd0);
    end
    pulse_start();
    step();
    step();
    chk("halt_start_ignored", {31'd0, IM_Req}, 32'd0);
    chk("halt_stays", {31'd0, Halted}, 32'd1);
    chk("halt_no_retire", {31'd0, Retire}, 32'd0);
    do_reset();
    chk("halt_rst_halted", {31'd0, Halted}, 32'd0);
    chk("halt_rst_err", {31'd0, Err}, 32'd0);
    chk("halt_rst_pc", {16'd0, PC_Out}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle successor to the team's single-cycle 16-bit CPU. It keeps the same 26-bit instruction format and the same ALU/branch semantics, and splits each instruction into FETCH/EXEC/MEM states. Instruction and data memories sit outside the block, behind req/ack handshakes that tolerate any number of wait states. It adds a hard-wired zero register, BNE, NOR, HALT and an illegal-opcode flag.

## Interface
Parameters:
- DATA_W, 16, register/ALU/data width (≥16)
- PC_W, 16, PC and memory address width (≤DATA_W)
- RESET_PC, 0, PC value loaded on reset

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  one-cycle pulse; leaves IDLE and begins fetching at PC
- IM_Req  out  1  instruction fetch request
- IM_Addr  out  PC_W  fetch address (= PC)
- IM_Ack  in  1  fetch complete; IM_RData valid this cycle
- IM_RData  in  26  instruction word
- DM_Req  out  1  data access request
- DM_We  out  1  1 = store, 0 = load (valid while DM_Req)
- DM_Addr  out  PC_W  ALU_Result[PC_W-1:0]
- DM_WData  out  DATA_W  rt value
- DM_Ack  in  1  access complete; DM_RData valid this cycle for loads
- DM_RData  in  DATA_W  load data
- PC_Out  out  PC_W  current PC
- Retire  out  1  one-cycle pulse per completed instruction
- Halted  out  1  HALT executed
- Err  out  1  sticky illegal-opcode/funct flag

## Operation
- Fields: OP[25:20], RS[19:17], RT[16:14], RD[13:11], IMM[13:0] (sign-extended to DATA_W), FUNCT[5:0], JT[15:0] (zero-extended or truncated to PC_W).
- Register file: 8 × DATA_W. R0 always reads 0, and writes to R0 are discarded.
- Sequencing: PC+1 is the default next PC; all PC arithmetic is mod 2^PC_W.
- Opcodes:
  - 0x00 R-type, with FUNCT 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT (signed, result 1/0). Result is written to RD.
  - 0x08 ADDI: RT = RS + IMM.
  - 0x23 LW: RT = mem[RS + IMM].
  - 0x2B SW: mem[RS + IMM] = RT.
  - 0x04 BEQ / 0x05 BNE: if the condition holds, PC = PC+1+IMM.
  - 0x02 J: PC = JT.
  - 0x3F HALT.
- Arithmetic: ADD/SUB wrap mod 2^DATA_W, with no overflow trap.
- Illegal OP/FUNCT: executes as NOP (PC+1, no write), sets Err, and still pulses Retire.
- FSM states: IDLE, FETCH, EXEC, MEM, HALT.
  - IDLE: START → FETCH. START is ignored in every other state.
  - FETCH: IM_Req=1. On IM_Ack, latch the IR and go to EXEC.
  - EXEC: ALU computes. LW/SW → MEM. HALT → HALT state with Retire. Everything else does its register write/PC update at this edge, Retire=1, → FETCH.
  - MEM: DM_Req=1. On DM_Ack, LW writes RT; PC+1, Retire=1, → FETCH.
  - HALT: Halted=1. Only RST leaves this state.

## Timing
- Reset values: state IDLE; PC = RESET_PC; all registers 0; IM_Req = DM_Req = DM_We = Retire = Halted = Err = 0.
- RST has priority over everything. If asserted mid-FETCH/MEM, the request drops on the cycle after the reset edge and any pending ack is ignored.
- IM_Ack/DM_Ack may be high in the same cycle the request rises (zero-wait).
- Request lines and IM_Addr/DM_Addr/DM_We/DM_WData stay stable until the ack cycle, and deassert the cycle after the ack.
- Ack while the corresponding request is low is ignored.
- Latency with zero-wait memory:
  - ALU, branch, J: 2 cycles.
  - LW, SW: 3 cycles.
  - Each wait state adds one cycle.
- Retire is high in the EXEC or MEM cycle whose edge commits the instruction. PC_Out shows the new PC the following cycle.
- Register read occurs in EXEC from the latched IR. A write committed at an edge is visible to the next instruction, so no hazards exist.

## Test plan
- Reset to RESET_PC=0, pulse START, zero-wait. Program: ADDI R1,R0,5; ADDI R2,R0,7; ADD R3,R1,R2; SW R3,0(R0). Required: DM write addr 0, data 12; four Retire pulses in 9 cycles.
- Program: ADDI R1,R0,3; ADDI R2,R0,5; SUB R4,R1,R2; SLT R5,R1,R2; SW R4,1(R0); SW R5,2(R0). Required: mem[1]=0xFFFE, mem[2]=1.
- LW with DM_Ack delayed 3 cycles. Required: DM_Req high 4 cycles with DM_Addr constant, then RT gets DM_RData=0xBEEF.
- BEQ R0,R0,IMM=-2 at PC=5 → PC_Out=4. BNE R0,R0 → PC=6. J 0x0010 → PC=0x10. ADDI R0,R0,9 then SW R0 stores 0.
- RST asserted while DM_Req is waiting. Required: DM_Req=0 next cycle, PC=0, state IDLE, and a late DM_Ack has no effect.
- Sequence: OP 0x11 (illegal), then HALT. Required: Err=1 with one Retire, PC+1. Then Halted=1, IM_Req stays 0, START is ignored until RST.
